// File: rtl/mult_seq_ctrl_pkg.sv
// Shared types and constants for the sequential multiplier controller:
// state encoding, register-file map and a constant-foldable clog2.
package mult_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FETCH,
    ADD,
    SHIFT,
    FIN
  } state_t;

  localparam int REG_A  = 0;
  localparam int REG_B  = 1;
  localparam int REG_LO = 2;
  localparam int REG_HI = 3;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mult_iter_cnt.sv
// Iteration counter for the multiplier sequencer: sync clear, count enable,
// and a flag that marks the final iteration.
module mult_iter_cnt #(
  parameter int ITER = 16,
  parameter int CW   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          last
);

  localparam logic [CW-1:0] LAST_VAL = CW'(ITER - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + ONE;
    end
  end

  assign last = (count == LAST_VAL);

endmodule

// File: rtl/mult_seq_ctrl.sv
// Control sequencer for a shift-and-add multiplier: walks CLEAR, then
// FETCH/ADD/SHIFT once per multiplier digit, then a one-cycle FIN.
module mult_seq_ctrl
  import mult_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1,
  parameter int NREG  = 5,
  localparam int ITER = WIDTH / DIGIT,
  localparam int CW   = clog2(ITER)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            acc_mode,
  input  logic            msb_first,
  output logic            busy,
  output logic            done,
  output logic            ppgen_en,
  output logic            add_en,
  output logic            shift_en,
  output logic            left_right,
  output logic [NREG-1:0] rd_enA,
  output logic [NREG-1:0] rd_enB,
  output logic [NREG-1:0] wr_en,
  output logic [CW-1:0]   iter
);

  if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("mult_seq_ctrl: WIDTH must be a power of two >= 4");
  end
  if (DIGIT != 1 && DIGIT != 2) begin : g_bad_digit
    $error("mult_seq_ctrl: DIGIT must be 1 or 2");
  end
  if (NREG < 5) begin : g_bad_nreg
    $error("mult_seq_ctrl: NREG must be 5 or greater");
  end

  localparam logic [NREG-1:0] ONE_HOT = NREG'(1);
  localparam logic [NREG-1:0] EN_A    = ONE_HOT << REG_A;
  localparam logic [NREG-1:0] EN_B    = ONE_HOT << REG_B;
  localparam logic [NREG-1:0] EN_LO   = ONE_HOT << REG_LO;
  localparam logic [NREG-1:0] EN_HI   = ONE_HOT << REG_HI;

  state_t          state;
  state_t          next_state;
  logic            acc_lat;
  logic            msb_lat;
  logic [CW-1:0]   iter_cnt;
  logic            iter_last;
  logic            cnt_clr;
  logic            cnt_en;

  // Mode bits are captured only on an accepted start so later toggles are inert.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc_lat <= 1'b0;
      msb_lat <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && start && !abort) begin
        acc_lat <= acc_mode;
        msb_lat <= msb_first;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = CLEAR;
      CLEAR:   next_state = FETCH;
      FETCH:   next_state = ADD;
      ADD:     next_state = SHIFT;
      SHIFT:   next_state = iter_last ? FIN : FETCH;
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (abort) begin
      next_state = IDLE;
    end
  end

  // Counter returns to zero whenever the operation ends, normally or by abort.
  assign cnt_clr = (next_state == IDLE) || (next_state == FIN);
  assign cnt_en  = (state == SHIFT) && (next_state == FETCH);

  mult_iter_cnt #(
    .ITER (ITER),
    .CW   (CW)
  ) u_iter_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (iter_cnt),
    .last  (iter_last)
  );

  always_comb begin
    busy       = (state != IDLE);
    done       = 1'b0;
    ppgen_en   = 1'b0;
    add_en     = 1'b0;
    shift_en   = 1'b0;
    left_right = 1'b0;
    rd_enA     = '0;
    rd_enB     = '0;
    wr_en      = '0;
    iter       = iter_cnt;
    case (state)
      CLEAR: begin
        if (!acc_lat) wr_en = EN_LO | EN_HI;
      end
      FETCH: begin
        ppgen_en = 1'b1;
        rd_enA   = EN_A;
        rd_enB   = EN_B;
      end
      ADD: begin
        add_en = 1'b1;
        rd_enA = EN_HI;
        wr_en  = EN_HI;
      end
      SHIFT: begin
        shift_en   = 1'b1;
        left_right = msb_lat;
        rd_enA     = EN_LO;
        rd_enB     = EN_HI;
        wr_en      = EN_LO | EN_HI;
      end
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: per-cycle timing model, mode table,
// done-time scoreboard and hand-written abort/reset/back-to-back sequences.
module tb_mult_seq_ctrl;

  localparam int ITER  = 16;
  localparam int FIN_K = 2 + 3 * ITER;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       ppgen;
    logic       add;
    logic       shift;
    logic       lr;
    logic [4:0] rda;
    logic [4:0] rdb;
    logic [4:0] wr;
    logic [3:0] iter;
  } out_t;

  typedef struct {
    bit         acc;
    bit         msb;
    logic [4:0] exp_clear_wr;
    bit         exp_lr;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, start, abort, acc_mode, msb_first;
  logic       busy, done, ppgen_en, add_en, shift_en, left_right;
  logic [4:0] rd_enA, rd_enB, wr_en;
  logic [3:0] iter;

  logic       start2;
  logic       busy2, done2, ppgen2, add2, shift2, lr2;
  logic [4:0] rda2, rdb2, wr2;
  logic [2:0] iter2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nshift;
  int exp_q[$];
  out_t act;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mult_seq_ctrl #(.WIDTH(16), .DIGIT(1), .NREG(5)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .acc_mode(acc_mode), .msb_first(msb_first),
    .busy(busy), .done(done), .ppgen_en(ppgen_en), .add_en(add_en),
    .shift_en(shift_en), .left_right(left_right),
    .rd_enA(rd_enA), .rd_enB(rd_enB), .wr_en(wr_en), .iter(iter)
  );

  mult_seq_ctrl #(.WIDTH(16), .DIGIT(2), .NREG(5)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(1'b0),
    .acc_mode(1'b1), .msb_first(1'b0),
    .busy(busy2), .done(done2), .ppgen_en(ppgen2), .add_en(add2),
    .shift_en(shift2), .left_right(lr2),
    .rd_enA(rda2), .rd_enB(rdb2), .wr_en(wr2), .iter(iter2)
  );

  always_comb act = {busy, done, ppgen_en, add_en, shift_en, left_right,
                     rd_enA, rd_enB, wr_en, iter};

  // Every done pulse must match the oldest outstanding expected completion cycle.
  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL sb_done unexpected done at cycle %0d", cyc);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (e != cyc) begin
          errors++;
          $display("[TB] FAIL sb_done got cycle=%0d exp cycle=%0d", cyc, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  // Expected outputs k cycles after the accepting edge; k<=0 or k>FIN_K is idle.
  function automatic out_t expModel(input int k, input vec_t v);
    out_t o;
    int i, ph;
    o = '0;
    if (k < 1 || k > FIN_K) return o;
    o.busy = 1'b1;
    if (k == 1) begin
      o.wr = v.exp_clear_wr;
    end else if (k == FIN_K) begin
      o.done = 1'b1;
    end else begin
      i  = (k - 2) / 3;
      ph = (k - 2) % 3;
      o.iter = 4'(i);
      case (ph)
        0: begin o.ppgen = 1'b1; o.rda = 5'b00001; o.rdb = 5'b00010; end
        1: begin o.add = 1'b1; o.rda = 5'b01000; o.wr = 5'b01000; end
        default: begin
          o.shift = 1'b1; o.lr = v.exp_lr;
          o.rda = 5'b00100; o.rdb = 5'b01000; o.wr = 5'b01100;
        end
      endcase
    end
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic acc, input logic msb);
    start     = s;
    abort     = a;
    acc_mode  = acc;
    msb_first = msb;
  endtask

  task automatic checkOutput(input string name, input int k, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s k=%0d got=%h exp=%h", name, k, act, exp);
    end
  endtask

  task automatic checkValue(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Accept a start, then invert the mode inputs so only the latched values matter.
  task automatic launch(input vec_t v, input bit expect_done);
    applyStimulus(1'b1, 1'b0, v.acc, v.msb);
    if (expect_done) exp_q.push_back(cyc + FIN_K);
    step();
    applyStimulus(1'b0, 1'b0, ~v.acc, ~v.msb);
  endtask

  task automatic checkRun(input string name, input vec_t v, input int kfirst, input int klast);
    for (int k = kfirst; k <= klast; k++) begin
      checkOutput(name, k, expModel(k, v));
      if (shift_en) nshift++;
      step();
    end
  endtask

  vec_t vecs[4];
  vec_t plain;

  initial begin
    vecs[0] = '{acc: 1'b0, msb: 1'b0, exp_clear_wr: 5'b01100, exp_lr: 1'b0};
    vecs[1] = '{acc: 1'b0, msb: 1'b1, exp_clear_wr: 5'b01100, exp_lr: 1'b1};
    vecs[2] = '{acc: 1'b1, msb: 1'b0, exp_clear_wr: 5'b00000, exp_lr: 1'b0};
    vecs[3] = '{acc: 1'b1, msb: 1'b1, exp_clear_wr: 5'b00000, exp_lr: 1'b1};
    plain   = vecs[0];

    rst = 1'b1;
    start2 = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    checkOutput("reset_state", 0, '0);
    rst = 1'b0;

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("abort_beats_start", 0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("rst_beats_start", 0, '0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step();

    // Full operations over the mode table; vector 1 also pulses start mid-run.
    for (int v = 0; v < 4; v++) begin
      nshift = 0;
      launch(vecs[v], 1'b1);
      for (int k = 1; k <= FIN_K; k++) begin
        checkOutput("op_table", k, expModel(k, vecs[v]));
        if (shift_en) nshift++;
        start = (v == 1 && k == 20);
        step();
      end
      start = 1'b0;
      checkOutput("op_table_idle", FIN_K + 1, '0);
      checkValue("shift_count", nshift, ITER);
      step();
    end

    launch(plain, 1'b0);
    checkRun("abort_run", plain, 1, 11);
    checkOutput("abort_run", 12, expModel(12, plain));
    abort = 1'b1;
    step();
    abort = 1'b0;
    checkOutput("abort_idle", 0, '0);
    repeat (60) step();
    checkOutput("abort_still_idle", 0, '0);

    launch(vecs[1], 1'b0);
    checkRun("rst_run", vecs[1], 1, 18);
    checkOutput("rst_run", 19, expModel(19, vecs[1]));
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("rst_mid_idle", 0, '0);
    nshift = 0;
    launch(plain, 1'b1);
    checkRun("after_rst", plain, 1, FIN_K);
    checkOutput("after_rst_idle", FIN_K + 1, '0);
    checkValue("after_rst_shifts", nshift, ITER);

    // Start held high: second op accepted from IDLE, done pulses FIN_K+1 apart.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(cyc + FIN_K);
    exp_q.push_back(cyc + 2 * FIN_K + 1);
    step();
    repeat (FIN_K) step();
    checkOutput("b2b_gap_idle", 0, '0);
    step();
    checkOutput("b2b_second_clear", 1, expModel(1, plain));
    start = 1'b0;
    repeat (FIN_K + 2) step();
    checkOutput("b2b_end_idle", 0, '0);

    // DIGIT=2 instance with accumulate mode: 8 iterations, no clear writes.
    begin
      int adds, done_k, clear_wr;
      adds = 0;
      done_k = -1;
      clear_wr = -1;
      start2 = 1'b1;
      step();
      start2 = 1'b0;
      for (int k = 1; k <= 27; k++) begin
        if (k == 1) clear_wr = int'(wr2);
        if (add2 && wr2 == 5'b01000) adds++;
        if (done2) begin
          checkValue("d2_single_done", done_k, -1);
          done_k = k;
        end
        step();
      end
      checkValue("d2_clear_wr", clear_wr, 0);
      checkValue("d2_add_cycles", adds, 8);
      checkValue("d2_done_cycle", done_k, 26);
      checkValue("d2_idle_busy", int'(busy2), 0);
    end

    checkValue("sb_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
